monitor_result_drain: RTL and testbench

MONITOR_RESULT_DRAIN -- requirements
Module: monitor_result_drain

---
 rtl/monitor_result_drain_pkg.sv | 29 ++
 rtl/drain_fifo.sv | 73 +++++++
 rtl/monitor_result_drain.sv | 159 +++++++++++++++
 tb/tb_monitor_result_drain.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/monitor_result_drain_pkg.sv
// Shared definitions for the monitor result drain: stream count, frame header
// nibble, serializer state encoding and the FIFO entry layout.
package monitor_result_drain_pkg;

  localparam int NSTREAMS = 4;
  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_B3,
    ST_B2,
    ST_B1,
    ST_B0
  } ser_state_e;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] value;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Header byte announcing which stream the following four value bytes belong to.
  function automatic logic [7:0] header_byte(input logic [1:0] id);
    return {HDR_NIBBLE, id, 2'b00};
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous show-ahead capture FIFO with registered full/empty flags.
// A push while full is refused even if a pop happens in the same cycle,
// because acceptance is decided on the registered full flag.
module drain_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push  = push && !full_q;
  assign do_pop   = pop && !empty_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

  // Next pointer/occupancy values and the flags derived from the next occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/monitor_result_drain.sv
// Captures per-stream monitor results into pending slots, arbitrates them into
// a capture FIFO (lowest stream first) and serializes each entry as a 5-byte
// frame: header {A, id, 00} followed by the 32-bit value, MSB first.
import monitor_result_drain_pkg::*;

module monitor_result_drain #(
  parameter int NSTREAMS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NSTREAMS-1:0] res_valid,
  input  logic [31:0]         result_0,
  input  logic [31:0]         result_1,
  input  logic [31:0]         result_2,
  input  logic [31:0]         result_3,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          drop_cnt
);

  logic [31:0]         result_arr [NSTREAMS];
  logic [NSTREAMS-1:0] pend_q, pend_d;
  logic [31:0]         slot_q [NSTREAMS];
  logic [31:0]         slot_d [NSTREAMS];
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [2:0]          drops;
  logic [8:0]          drop_sum;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]          sel_id;
  entry_t              push_entry, pop_entry;

  ser_state_e          state_q;
  logic [31:0]         shift_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;

  assign result_arr[0] = result_0;
  assign result_arr[1] = result_1;
  assign result_arr[2] = result_2;
  assign result_arr[3] = result_3;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign drop_cnt = drop_cnt_q;

  // Arbiter: pick the lowest-index pending slot; stall while the FIFO is full.
  always_comb begin
    fifo_push = 1'b0;
    sel_id    = '0;
    for (int i = NSTREAMS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        fifo_push = 1'b1;
        sel_id    = 2'(i);
      end
    end
    if (fifo_full) fifo_push = 1'b0;
    push_entry.id    = sel_id;
    push_entry.value = slot_q[sel_id];
  end

  // Capture into pending slots; an overwrite of a slot not drained this cycle is a drop.
  always_comb begin
    pend_d = pend_q;
    slot_d = slot_q;
    drops  = '0;
    if (fifo_push) pend_d[sel_id] = 1'b0;
    for (int i = 0; i < NSTREAMS; i++) begin
      if (en && res_valid[i]) begin
        slot_d[i] = result_arr[i];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(fifo_push && (sel_id == 2'(i)))) drops = drops + 3'd1;
      end
    end
    drop_sum   = {1'b0, drop_cnt_q} + {6'b0, drops};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Pending flags and the saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Slot values need no reset; pend_q qualifies them.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  // Serializer FSM with registered byte/valid outputs; advances only on a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_q    <= pop_entry.value;
            tx_data_q  <= header_byte(pop_entry.id);
            tx_valid_q <= 1'b1;
            state_q    <= ST_HDR;
          end
        end
        ST_HDR, ST_B3, ST_B2, ST_B1: begin
          if (tx_ready) begin
            tx_data_q <= shift_q[31:24];
            shift_q   <= {shift_q[23:0], 8'h00};
            case (state_q)
              ST_HDR:  state_q <= ST_B3;
              ST_B3:   state_q <= ST_B2;
              ST_B2:   state_q <= ST_B1;
              default: state_q <= ST_B0;
            endcase
          end
        end
        ST_B0: begin
          if (tx_ready) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          tx_data_q  <= '0;
          tx_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_result_drain.sv
// Directed testbench for monitor_result_drain: capture, arbitration order,
// backpressure, overflow/drop counting, saturation, enable gating and reset.
module tb_monitor_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  res_valid;
  logic [31:0] result_0, result_1, result_2, result_3;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  monitor_result_drain #(
    .NSTREAMS   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .res_valid (res_valid),
    .result_0  (result_0),
    .result_1  (result_1),
    .result_2  (result_2),
    .result_3  (result_3),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .drop_cnt  (drop_cnt)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the capture inputs; value goes to the selected stream's result bus.
  task automatic applyStimulus(input logic en_v, input logic [3:0] valid_v,
                               input int stream, input logic [31:0] value);
    en        = en_v;
    res_valid = valid_v;
    case (stream)
      0: result_0 = value;
      1: result_1 = value;
      2: result_2 = value;
      default: result_3 = value;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for a valid byte, check it, then let the handshake edge pass.
  task automatic expectByte(input string tag, input logic [7:0] exp);
    int waited = 0;
    while (tx_valid !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput({tag, " valid"}, {31'b0, tx_valid}, 32'd1);
    checkOutput(tag, {24'b0, tx_data}, {24'b0, exp});
    tick();
  endtask

  task automatic expectFrame(input string tag, input logic [1:0] id, input logic [31:0] value);
    logic [7:0] hdr;
    hdr = {4'hA, id, 2'b00};
    expectByte({tag, " hdr"}, hdr);
    expectByte({tag, " b3"}, value[31:24]);
    expectByte({tag, " b2"}, value[23:16]);
    expectByte({tag, " b1"}, value[15:8]);
    expectByte({tag, " b0"}, value[7:0]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b0;
    tx_ready = 1'b1;
    en       = 1'b0;
    res_valid = 4'b0000;
    result_0 = '0; result_1 = '0; result_2 = '0; result_3 = '0;

    // Reset state
    tick(); tick();
    checkOutput("reset tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("reset tx_data", {24'b0, tx_data}, 32'd0);
    checkOutput("reset drop_cnt", {24'b0, drop_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // Single capture with latency: edge N capture, header visible after N+2
    $display("[TB] single capture");
    applyStimulus(1'b1, 4'b0001, 0, 32'h12345678);
    tick();
    applyStimulus(1'b1, 4'b0000, 0, 32'h12345678);
    checkOutput("lat N tx_valid", {31'b0, tx_valid}, 32'd0);
    tick();
    checkOutput("lat N+1 tx_valid", {31'b0, tx_valid}, 32'd0);
    tick();
    checkOutput("lat N+2 tx_valid", {31'b0, tx_valid}, 32'd1);
    checkOutput("lat N+2 hdr", {24'b0, tx_data}, 32'h000000A0);
    expectFrame("single", 2'd0, 32'h12345678);
    checkOutput("single idle gap", {31'b0, tx_valid}, 32'd0);
    checkOutput("single drop_cnt", {24'b0, drop_cnt}, 32'd0);

    // Simultaneous captures: lowest stream first
    $display("[TB] simultaneous capture");
    result_1 = 32'd5;
    result_3 = 32'hFFFFFFFF;
    applyStimulus(1'b1, 4'b1010, 1, 32'd5);
    tick();
    applyStimulus(1'b1, 4'b0000, 1, 32'd5);
    expectFrame("simul s1", 2'd1, 32'd5);
    expectFrame("simul s3", 2'd3, 32'hFFFFFFFF);
    checkOutput("simul drop_cnt", {24'b0, drop_cnt}, 32'd0);

    // Backpressure: stall 10 cycles while B2 is on the bus
    $display("[TB] backpressure");
    applyStimulus(1'b1, 4'b0010, 1, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b1, 4'b0000, 1, 32'hDEADBEEF);
    expectByte("bp hdr", 8'hA4);
    expectByte("bp b3", 8'hDE);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp hold valid", {31'b0, tx_valid}, 32'd1);
      checkOutput("bp hold data", {24'b0, tx_data}, 32'h000000AD);
    end
    tx_ready = 1'b1;
    expectByte("bp b2", 8'hAD);
    expectByte("bp b1", 8'hBE);
    expectByte("bp b0", 8'hEF);
    checkOutput("bp after frame", {31'b0, tx_valid}, 32'd0);

    // Enable low: pulses are ignored
    $display("[TB] enable gating");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, i % 4, 32'h55AA0000 + i);
      tick();
    end
    applyStimulus(1'b1, 4'b0000, 0, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("en0 no frame", {31'b0, tx_valid}, 32'd0);
    checkOutput("en0 drop_cnt", {24'b0, drop_cnt}, 32'd0);

    // Overflow: a blocker frame occupies the serializer, then 6 captures on stream 2
    $display("[TB] overflow");
    tx_ready = 1'b0;
    applyStimulus(1'b1, 4'b0001, 0, 32'hCAFE0000);
    tick();
    applyStimulus(1'b1, 4'b0000, 0, 32'hCAFE0000);
    tick(); tick();
    checkOutput("ovf blocker valid", {31'b0, tx_valid}, 32'd1);
    for (int v = 1; v <= 6; v++) begin
      applyStimulus(1'b1, 4'b0100, 2, 32'(v));
      tick();
    end
    applyStimulus(1'b1, 4'b0000, 2, 32'd0);
    tick(); tick();
    checkOutput("ovf drop_cnt", {24'b0, drop_cnt}, 32'd1);
    tx_ready = 1'b1;
    expectFrame("ovf blocker", 2'd0, 32'hCAFE0000);
    expectFrame("ovf v1", 2'd2, 32'd1);
    expectFrame("ovf v2", 2'd2, 32'd2);
    expectFrame("ovf v3", 2'd2, 32'd3);
    expectFrame("ovf v4", 2'd2, 32'd4);
    expectFrame("ovf v6", 2'd2, 32'd6);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("ovf drained", {31'b0, tx_valid}, 32'd0);
    checkOutput("ovf drop_cnt after", {24'b0, drop_cnt}, 32'd1);

    // Saturation of the drop counter
    $display("[TB] drop saturation");
    tx_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 4'b1111, i % 4, 32'(i));
      tick();
    end
    checkOutput("sat drop_cnt", {24'b0, drop_cnt}, 32'd255);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat drop_cnt hold", {24'b0, drop_cnt}, 32'd255);
    applyStimulus(1'b1, 4'b0000, 0, 32'd0);

    // Asynchronous reset clears everything without a clock edge
    rst = 1'b0;
    #1;
    checkOutput("async rst tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("async rst tx_data", {24'b0, tx_data}, 32'd0);
    checkOutput("async rst drop_cnt", {24'b0, drop_cnt}, 32'd0);
    tick();

    // Reset mid-frame after B3
    $display("[TB] reset mid-frame");
    tx_ready = 1'b1;
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0001, 0, 32'h11223344);
    tick();
    applyStimulus(1'b1, 4'b0000, 0, 32'h11223344);
    expectByte("mid hdr", 8'hA0);
    expectByte("mid b3", 8'h11);
    rst = 1'b0;
    #1;
    checkOutput("mid rst tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("mid rst tx_data", {24'b0, tx_data}, 32'd0);
    checkOutput("mid rst drop_cnt", {24'b0, drop_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 4'b1000, 3, 32'h80000001);
    tick();
    applyStimulus(1'b1, 4'b0000, 3, 32'h80000001);
    tick(); tick();
    checkOutput("post rst hdr valid", {31'b0, tx_valid}, 32'd1);
    checkOutput("post rst hdr", {24'b0, tx_data}, 32'h000000AC);
    expectFrame("post rst", 2'd3, 32'h80000001);
    tick();
    checkOutput("post rst idle", {31'b0, tx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
